// File: rtl/game_pkg.sv
// game_pkg: key bit encoding shared with the sprite controller, plus the debounce state type.
package game_pkg;

    localparam int NKEYS     = 4;
    localparam int KEY_RIGHT = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_LEFT  = 3;

    typedef enum logic [1:0] {UP, CHECK_DOWN, DOWN, CHECK_UP} deb_state_t;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchroniser, stability counter and press/release FSM for one key.
module debounce_channel
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int               CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             s;
    deb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, press_nxt, rel_nxt;
    logic             settled;

    assign s       = sync[1];
    assign settled = cnt == LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= 2'b11;
            state <= UP;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
            rel   <= rel_nxt;
        end
    end

    // Counter is cleared on every state change and only advances while checking.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        case (state)
            UP: if (!s) begin
                state_nxt = CHECK_DOWN;
                cnt_nxt   = '0;
            end
            CHECK_DOWN: if (s) begin
                state_nxt = UP;
                cnt_nxt   = '0;
            end else if (settled) begin
                state_nxt = DOWN;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
                press_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
            DOWN: if (s) begin
                state_nxt = CHECK_UP;
                cnt_nxt   = '0;
            end
            CHECK_UP: if (!s) begin
                state_nxt = DOWN;
                cnt_nxt   = '0;
            end else if (settled) begin
                state_nxt = UP;
                cnt_nxt   = '0;
                level_nxt = 1'b1;
                rel_nxt   = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: independent debounce channels turning raw active-low buttons into a clean key vector.
module key_debouncer #(
    parameter int NKEYS           = game_pkg::NKEYS,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NKEYS-1:0] key_raw,
    output logic [NKEYS-1:0] key,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release
);

    for (genvar i = 0; i < NKEYS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (key_raw[i]),
            .level  (key[i]),
            .press  (key_press[i]),
            .rel    (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: scoreboard bench; a run-length model predicts every cycle's outputs.
module tb_key_debouncer;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] key_raw = '1;
    logic [N-1:0] key, key_press, key_release;

    key_debouncer #(.NKEYS(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_raw    (key_raw),
        .key        (key),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    logic [3*N-1:0] exp_q[$];
    int             n_cmp = 0;
    int             n_err = 0;

    // Model state: raw samples seen by the clock, and how long the synchronised input has disagreed with key.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_key, m_press, m_rel;
    int           run[N];

    task automatic model_reset();
        hist = {'1, '1};
        m_key = '1;
        m_press = '0;
        m_rel = '0;
        for (int i = 0; i < N; i++) run[i] = 0;
    endtask

    // A key takes a new level once the synchronised input has differed from it on D+1 consecutive edges.
    task automatic model_edge(input logic [N-1:0] r, input logic rn);
        logic [N-1:0] seen;
        if (!rn) begin
            model_reset();
        end else begin
            seen = hist.pop_front();
            hist.push_back(r);
            m_press = '0;
            m_rel = '0;
            for (int i = 0; i < N; i++) begin
                run[i] = (seen[i] != m_key[i]) ? run[i] + 1 : 0;
                if (run[i] == D + 1) begin
                    run[i] = 0;
                    m_key[i] = ~m_key[i];
                    if (m_key[i]) m_rel[i] = 1'b1;
                    else m_press[i] = 1'b1;
                end
            end
        end
        exp_q.push_back({m_key, m_press, m_rel});
    endtask

    task automatic step(input logic [N-1:0] r, input logic rn, input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            key_raw = r;
            reset_n = rn;
            @(posedge clk);
            model_edge(r, rn);
        end
    endtask

    always @(negedge clk) begin
        logic [3*N-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({key, key_press, key_release} !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t key/press/release got %b/%b/%b want %b/%b/%b",
                         $time, key, key_press, key_release, e[3*N-1:2*N], e[2*N-1:N], e[N-1:0]);
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        int           len;
        model_reset();
        step('1, 1'b0, 3);
        step('1, 1'b1, 20);
        step(4'b1110, 1'b1, 10);
        step(4'b1111, 1'b1, 10);
        step(4'b1011, 1'b1, 3);
        step(4'b1111, 1'b1, 10);
        step(4'b1101, 1'b1, 10);
        step(4'b1111, 1'b1, 10);
        step(4'b1100, 1'b1, 10);
        step(4'b1111, 1'b1, 10);
        step(4'b0111, 1'b1, 5);
        step(4'b0111, 1'b0, 1);
        step(4'b0111, 1'b1, 12);
        step(4'b1111, 1'b1, 10);
        for (int k = 0; k < 150; k++) begin
            r = N'($urandom);
            len = $urandom_range(1, 9);
            step(r, ($urandom_range(0, 39) != 0), 1);
            step(r, 1'b1, len);
        end
        step('1, 1'b1, 12);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
